// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//
// Turns a debounced push-button level into discrete gesture events: press,
// release, single click, double click, long press, plus a "held" level while
// a long press is being held down.
//
// Optional feature macro: BUTTON_EVENTS_DCLICK_EN
//   defined   - a short release opens a DCLICK_CYCLES window in which a second
//               press turns the gesture into a double click.
//   undefined - every short press completes as a click on its release edge and
//               dclick is tied to 0.
//
// Parameters
//   LONG_CYCLES   hold time (clk cycles) that turns a press into a long press
//   DCLICK_CYCLES window (clk cycles) after a short release for a second press
//
// Ports
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   sw_in        in   debounced switch level, 1 = pressed, synchronous to clk
//   press        out  one-cycle pulse on each accepted press
//   release_evt  out  one-cycle pulse on each accepted release
//   click        out  one-cycle pulse for a completed single short click
//   dclick       out  one-cycle pulse for a completed double click
//   long_press   out  one-cycle pulse when a hold reaches LONG_CYCLES
//   held         out  level, 1 while a long press is being held
// -----------------------------------------------------------------------------
module button_events #(
    parameter int unsigned LONG_CYCLES   = 12000000,
    parameter int unsigned DCLICK_CYCLES = 3600000
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw_in,
    output logic press,
    output logic release_evt,
    output logic click,
    output logic dclick,
    output logic long_press,
    output logic held
);

    localparam int unsigned TIMER_W = 24;

    if (LONG_CYCLES < 2 || LONG_CYCLES > 24'hFFFFFF) begin : g_bad_long
        $error("button_events: LONG_CYCLES out of range 2..2^24-1");
    end
    if (DCLICK_CYCLES < 2 || DCLICK_CYCLES > 24'hFFFFFF) begin : g_bad_dclick
        $error("button_events: DCLICK_CYCLES out of range 2..2^24-1");
    end

    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_HOLD
`ifdef BUTTON_EVENTS_DCLICK_EN
        ,
        S_WAIT2,
        S_PRESS2
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic                 sw_q;
    logic                 rise, fall;
    logic                 press_d, release_d, click_d, long_d;

    assign rise = sw_in & ~sw_q;
    assign fall = ~sw_in & sw_q;

`ifdef BUTTON_EVENTS_DCLICK_EN
    localparam logic [TIMER_W-1:0] DCLICK_LAST = TIMER_W'(DCLICK_CYCLES - 1);
    logic dclick_d;
`endif

    // Next-state and event decode. A fall always takes priority over a
    // long-press expiry, and a rise over a window expiry, so the edges the
    // user actually produced are never lost to a coincident timeout.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_EVENTS_DCLICK_EN
        dclick_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS;
                    press_d = 1'b1;
                end
            end
            S_PRESS: begin
                if (fall) begin
                    release_d = 1'b1;
`ifdef BUTTON_EVENTS_DCLICK_EN
                    state_d   = S_WAIT2;
`else
                    state_d   = S_IDLE;
                    click_d   = 1'b1;
`endif
                end else if (sw_in && timer_q == LONG_LAST) begin
                    state_d = S_HOLD;
                    long_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                end
            end
`ifdef BUTTON_EVENTS_DCLICK_EN
            S_WAIT2: begin
                if (rise) begin
                    state_d = S_PRESS2;
                    press_d = 1'b1;
                end else if (timer_q == DCLICK_LAST) begin
                    state_d = S_IDLE;
                    click_d = 1'b1;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    dclick_d  = 1'b1;
                end else if (sw_in && timer_q == LONG_LAST) begin
                    // Holding the second press turns it into a long press;
                    // the click owed for the first press is dropped.
                    state_d = S_HOLD;
                    long_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Timer restarts on every state change and otherwise counts up,
    // saturating so a long stay in IDLE or HOLD can never wrap it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            sw_q        <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_q        <= sw_in;
            press       <= press_d;
            release_evt <= release_d;
            click       <= click_d;
            long_press  <= long_d;
            held        <= (state_d == S_HOLD);
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

`ifdef BUTTON_EVENTS_DCLICK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dclick <= 1'b0;
        end else begin
            dclick <= dclick_d;
        end
    end
`else
    assign dclick = 1'b0;
`endif

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//
// Directed and random gestures for button_events with LONG_CYCLES=8 and
// DCLICK_CYCLES=4. The switch level of each scenario is described as a list
// of (level, length) runs; expected events are derived from those runs.
// -----------------------------------------------------------------------------
module tb_button_events;

    localparam int LONG   = 8;
    localparam int DCLICK = 4;

`ifdef BUTTON_EVENTS_DCLICK_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    logic sw_in;
    logic press, rel, click, dclick, long_press, held;

    int n_assert = 0;
    int n_fail   = 0;

    bit         lv[$];
    logic [5:0] exp_ev[];

    button_events #(
        .LONG_CYCLES  (LONG),
        .DCLICK_CYCLES(DCLICK)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_in      (sw_in),
        .press      (press),
        .release_evt(rel),
        .click      (click),
        .dclick     (dclick),
        .long_press (long_press),
        .held       (held)
    );

    always #5 clk = ~clk;

    task automatic add(input bit lvl, input int len);
        for (int i = 0; i < len; i++) lv.push_back(lvl);
    endtask

    // Expected outputs after each edge, bits {press,release,click,dclick,long,held}.
    // Every high run is one press; its length decides short vs long, and the
    // gap to the next run decides single vs double click.
    task automatic build_model();
        int  n, k, r, f, fprev;
        bit  armed, second;
        n = lv.size();
        exp_ev = new[n];
        for (int i = 0; i < n; i++) exp_ev[i] = '0;
        armed = 0;
        fprev = 0;
        k = 0;
        while (k < n) begin
            if (lv[k] && (k == 0 || !lv[k-1])) begin
                r = k;
                f = k;
                while (f < n && lv[f]) f++;
                second = 0;
                if (armed) begin
                    if (r - fprev <= DCLICK) second = 1;
                    else exp_ev[fprev + DCLICK][3] = 1'b1;
                    armed = 0;
                end
                exp_ev[r][5] = 1'b1;
                if (f - r > LONG) begin
                    exp_ev[r + LONG][1] = 1'b1;
                    for (int i = r + LONG; i < f; i++) exp_ev[i][0] = 1'b1;
                    if (f < n) exp_ev[f][4] = 1'b1;
                end else if (f < n) begin
                    exp_ev[f][4] = 1'b1;
                    if (second) exp_ev[f][2] = 1'b1;
                    else if (DC_EN) begin
                        armed = 1;
                        fprev = f;
                    end else exp_ev[f][3] = 1'b1;
                end
                k = f;
            end else begin
                k++;
            end
        end
        if (armed && fprev + DCLICK < n) exp_ev[fprev + DCLICK][3] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        logic [5:0] obs;
        obs = {press, rel, click, dclick, long_press, held};
        n_assert++;
        assert (obs === 6'b0) else begin
            n_fail++;
            $error("FAIL %s observed %b expected %b", tag, obs, 6'b0);
        end
    endtask

    // Called at a falling clock edge; releases reset at a falling edge too.
    task automatic do_reset(input bit sw_rel);
        sw_in = 1'b0;
        rstn  = 1'b0;
        #1;
        check_idle("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_hold");
        sw_in = sw_rel;
        rstn  = 1'b1;
    endtask

    task automatic drive_phase(input string tag);
        logic [5:0] obs;
        build_model();
        for (int k = 0; k < lv.size(); k++) begin
            sw_in = lv[k];
            @(posedge clk);
            @(negedge clk);
            obs = {press, rel, click, dclick, long_press, held};
            n_assert++;
            assert (obs === exp_ev[k]) else begin
                n_fail++;
                $error("FAIL %s edge %0d observed %b expected %b", tag, k, obs, exp_ev[k]);
            end
        end
    endtask

    initial begin
        bit lvl;
        rstn  = 1'b1;
        sw_in = 1'b0;
        @(negedge clk);

        lv.delete(); add(0, 2); add(1, 3); add(0, 12);
        do_reset(lv[0]); drive_phase("single_click");

        lv.delete(); add(0, 2); add(1, 2); add(0, 2); add(1, 2); add(0, 10);
        do_reset(lv[0]); drive_phase("double_click");

        lv.delete(); add(0, 1); add(1, 20); add(0, 10);
        do_reset(lv[0]); drive_phase("long_hold");

        lv.delete(); add(0, 1); add(1, 2); add(0, 3); add(1, 7); add(0, 10);
        do_reset(lv[0]); drive_phase("gap3_second7");

        lv.delete(); add(0, 1); add(1, 2); add(0, 4); add(1, 2); add(0, 10);
        do_reset(lv[0]); drive_phase("gap4_rise_wins");

        lv.delete(); add(0, 1); add(1, 2); add(0, 5); add(1, 2); add(0, 10);
        do_reset(lv[0]); drive_phase("gap5_timeout");

        lv.delete(); add(0, 1); add(1, 8); add(0, 6); add(1, 9); add(0, 10);
        do_reset(lv[0]); drive_phase("long_boundary");

        lv.delete(); add(0, 1); add(1, 2); add(0, 3); add(1, 12); add(0, 10);
        do_reset(lv[0]); drive_phase("second_long");

        // Reset while waiting for a second press, switch already down at release.
        lv.delete(); add(1, 2); add(0, 2);
        do_reset(lv[0]); drive_phase("pre_reset_wait2");
        lv.delete(); add(1, 3); add(0, 12);
        do_reset(lv[0]); drive_phase("after_reset_press");

        lv.delete();
        lvl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            add(lvl, $urandom_range(1, 12));
            lvl = ~lvl;
        end
        add(0, 12);
        do_reset(lv[0]); drive_phase("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
